// File: rtl/motor_control.sv
// Hex speed command to single-output PWM motor drive.
// Duty updates only at PWM period boundaries, optionally slew-limited.
module motor_control #(
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned RAMP_STEP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hex_speed,
  output logic       pwm
);

  localparam int unsigned SPD_W = 4;
  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [SPD_W-1:0] CNT_LAST = SPD_W'(14);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [SPD_W-1:0] hs_q;
  logic [SPD_W-1:0] cnt_q, cnt_d;
  logic [SPD_W-1:0] duty_q, duty_d;
  logic [SPD_W-1:0] diff, step;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             pwm_q, pwm_d;
  logic             tick, boundary;

  // Prescaler, step counter and boundary-gated duty update
  always_comb begin
    tick     = (pre_q == PRE_LAST);
    boundary = tick && (cnt_q == CNT_LAST);
    pre_d    = tick ? '0 : pre_q + PRE_W'(1);

    cnt_d = cnt_q;
    if (boundary) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + SPD_W'(1);
    end

    if (hs_q >= duty_q) begin
      diff = hs_q - duty_q;
    end else begin
      diff = duty_q - hs_q;
    end
    // Step never exceeds the remaining distance, so the ramp cannot overshoot
    step = (32'(diff) < RAMP_STEP) ? diff : SPD_W'(RAMP_STEP);

    duty_d = duty_q;
    if (boundary) begin
      if (RAMP_STEP == 0) begin
        duty_d = hs_q;
      end else if (hs_q >= duty_q) begin
        duty_d = duty_q + step;
      end else begin
        duty_d = duty_q - step;
      end
    end

    pwm_d = (cnt_q < duty_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q   <= '0;
      pre_q  <= '0;
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      hs_q   <= hex_speed;
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: tb/tb_motor_control.sv
// Directed bench for motor_control: base, ramp-limited and divided-clock instances.
module tb_motor_control;

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [3:0] hex_v [3];
  logic [2:0] pwm_v;
  int         n_checks = 0;
  int         n_errors = 0;

  always #10 clk = ~clk;

  motor_control #(.CLK_DIV(1), .RAMP_STEP(0)) u_base (
    .clk(clk), .rst(rst_v[0]), .hex_speed(hex_v[0]), .pwm(pwm_v[0]));
  motor_control #(.CLK_DIV(1), .RAMP_STEP(2)) u_ramp (
    .clk(clk), .rst(rst_v[1]), .hex_speed(hex_v[1]), .pwm(pwm_v[1]));
  motor_control #(.CLK_DIV(4), .RAMP_STEP(0)) u_div (
    .clk(clk), .rst(rst_v[2]), .hex_speed(hex_v[2]), .pwm(pwm_v[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One PWM period: expect n*div high samples then low; optional mid-period hex changes
  task automatic run_period(input int unsigned idx, input int unsigned div,
                            input int unsigned n, input string tag,
                            input int unsigned m1_at, input logic [3:0] m1_hex,
                            input int unsigned m2_at, input logic [3:0] m2_hex);
    logic [63:0] got;
    logic [63:0] exp;
    got = '0;
    exp = '0;
    for (int i = 0; i < int'(15 * div); i++) begin
      @(negedge clk);
      got[i] = pwm_v[idx];
      exp[i] = (i < int'(n * div));
      if (m1_at != 0 && i + 1 == int'(m1_at)) hex_v[idx] = m1_hex;
      if (m2_at != 0 && i + 1 == int'(m2_at)) hex_v[idx] = m2_hex;
    end
    check(tag, got, exp);
  endtask

  initial begin
    rst_v    = '0;
    hex_v[0] = 4'h3;
    hex_v[1] = 4'h7;
    hex_v[2] = 4'h5;

    repeat (5) begin
      @(negedge clk);
      check("rst_hold", 64'(pwm_v[0]), 64'(0));
    end

    // Base instance: hex written at the start of a period shows up one period later
    rst_v[0] = 1'b1;
    run_period(0, 1, 0,  "first_period", 0, 4'h0, 0, 4'h0);
    hex_v[0] = 4'h0;
    run_period(0, 1, 3,  "spd3",         0, 4'h0, 0, 4'h0);
    hex_v[0] = 4'hF;
    run_period(0, 1, 0,  "spd0",         0, 4'h0, 0, 4'h0);
    run_period(0, 1, 15, "spdF_a",       0, 4'h0, 0, 4'h0);
    hex_v[0] = 4'h1;
    run_period(0, 1, 15, "spdF_b",       0, 4'h0, 0, 4'h0);
    hex_v[0] = 4'h8;
    run_period(0, 1, 1,  "spd1",         0, 4'h0, 0, 4'h0);
    hex_v[0] = 4'hC;
    run_period(0, 1, 8,  "spd8",         0, 4'h0, 0, 4'h0);
    hex_v[0] = 4'h3;
    run_period(0, 1, 12, "spdC",         0, 4'h0, 0, 4'h0);
    run_period(0, 1, 3,  "spd3_steady",  0, 4'h0, 0, 4'h0);
    run_period(0, 1, 3,  "mid_old",      5, 4'hC, 0, 4'h0);
    run_period(0, 1, 12, "mid_new",      3, 4'h1, 10, 4'hC);
    run_period(0, 1, 12, "revert",       14, 4'h5, 0, 4'h0);
    run_period(0, 1, 12, "bnd_same",     0, 4'h0, 0, 4'h0);
    run_period(0, 1, 5,  "bnd_after",    0, 4'h0, 0, 4'h0);

    // Ramp instance, RAMP_STEP=2
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b1;
    run_period(1, 1, 0, "ramp0", 0, 4'h0, 0, 4'h0);
    run_period(1, 1, 2, "ramp2", 0, 4'h0, 0, 4'h0);
    run_period(1, 1, 4, "ramp4", 0, 4'h0, 0, 4'h0);
    run_period(1, 1, 6, "ramp6", 0, 4'h0, 0, 4'h0);
    run_period(1, 1, 7, "ramp7a", 0, 4'h0, 0, 4'h0);
    hex_v[1] = 4'h1;
    run_period(1, 1, 7, "ramp7b", 0, 4'h0, 0, 4'h0);
    run_period(1, 1, 5, "ramp5", 0, 4'h0, 0, 4'h0);
    run_period(1, 1, 3, "ramp3", 0, 4'h0, 0, 4'h0);
    run_period(1, 1, 1, "ramp1a", 0, 4'h0, 0, 4'h0);
    run_period(1, 1, 1, "ramp1b", 0, 4'h0, 0, 4'h0);

    // Divided instance, CLK_DIV=4: 60-clock period
    rst_v[1] = 1'b0;
    rst_v[2] = 1'b1;
    run_period(2, 4, 0, "div_first", 0, 4'h0, 0, 4'h0);
    run_period(2, 4, 5, "div_spd5",  0, 4'h0, 0, 4'h0);
    repeat (10) @(negedge clk);
    check("div_pre_rst", 64'(pwm_v[2]), 64'(1));
    rst_v[2] = 1'b0;
    #1;
    check("div_rst_async", 64'(pwm_v[2]), 64'(0));
    repeat (3) begin
      @(negedge clk);
      check("div_rst_hold", 64'(pwm_v[2]), 64'(0));
    end
    rst_v[2] = 1'b1;
    run_period(2, 4, 0, "div_restart0", 0, 4'h0, 0, 4'h0);
    run_period(2, 4, 5, "div_restart5", 0, 4'h0, 0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
